// File: rtl/writeback_unit.sv
// Register-file writeback stage: commits execute results to a 32x32 GR file, splitting
// dual-destination bundles over two cycles. Optional same-cycle read bypass: WB_BYPASS_EN.
module writeback_unit #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [XLEN-1:0] result_i,
    input  logic [XLEN-1:0] result2_i,
    input  logic [4:0]      destination_i,
    input  logic [4:0]      destination2_i,
    input  logic [4:0]      rd_addr1_i,
    output logic [XLEN-1:0] rd_data1_o,
    input  logic [4:0]      rd_addr2_i,
    output logic [XLEN-1:0] rd_data2_o,
    output logic [31:0]     write_count_o
);

    typedef enum logic {
        IDLE,
        SECOND
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] gr [NREG];
    logic [XLEN-1:0] hold_data_p1;
    logic [4:0]      hold_d2_p1;

    logic            wr_en;
    logic [4:0]      wr_addr;
    logic [XLEN-1:0] wr_data;
    logic            hold_load;

    assign ready_o = (state == IDLE);

    // Single write port arbitration; result2 wins when both destinations collide.
    always_comb begin
        state_nxt = state;
        wr_en     = 1'b0;
        wr_addr   = '0;
        wr_data   = '0;
        hold_load = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (destination2_i == '0) begin
                        wr_en   = (destination_i != '0);
                        wr_addr = destination_i;
                        wr_data = result_i;
                    end else if (destination_i == '0 || destination_i == destination2_i) begin
                        wr_en   = 1'b1;
                        wr_addr = destination2_i;
                        wr_data = result2_i;
                    end else begin
                        wr_en     = 1'b1;
                        wr_addr   = destination_i;
                        wr_data   = result_i;
                        hold_load = 1'b1;
                        state_nxt = SECOND;
                    end
                end
            end
            SECOND: begin
                wr_en     = (hold_d2_p1 != '0);
                wr_addr   = hold_d2_p1;
                wr_data   = hold_data_p1;
                state_nxt = IDLE;
            end
        endcase
    end

    // Stage boundary: control state, hold registers and commit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            hold_data_p1  <= '0;
            hold_d2_p1    <= '0;
            write_count_o <= '0;
        end else begin
            state <= state_nxt;
            if (hold_load) begin
                hold_data_p1 <= result2_i;
                hold_d2_p1   <= destination2_i;
            end
            if (wr_en) begin
                write_count_o <= write_count_o + 32'd1;
            end
        end
    end

    // Stage boundary: general register array (r0 is never written).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                gr[i] <= '0;
            end
        end else if (wr_en) begin
            gr[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        rd_data1_o = (rd_addr1_i == '0) ? '0 : gr[rd_addr1_i];
        rd_data2_o = (rd_addr2_i == '0) ? '0 : gr[rd_addr2_i];
`ifdef WB_BYPASS_EN
        // wr_en already implies a nonzero wr_addr, so r0 stays zero here too.
        if (wr_en && wr_addr == rd_addr1_i) begin
            rd_data1_o = wr_data;
        end
        if (wr_en && wr_addr == rd_addr2_i) begin
            rd_data2_o = wr_data;
        end
`endif
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Bench for writeback_unit: directed literal checks plus randomized bundles compared
// every cycle against a register-array/queue reference model.
module tb_writeback_unit;

    logic        clk;
    logic        rst_n;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] result_i;
    logic [31:0] result2_i;
    logic [4:0]  destination_i;
    logic [4:0]  destination2_i;
    logic [4:0]  rd_addr1_i;
    logic [31:0] rd_data1_o;
    logic [4:0]  rd_addr2_i;
    logic [31:0] rd_data2_o;
    logic [31:0] write_count_o;

    int n_chk;
    int n_err;

    writeback_unit #(.XLEN(32), .NREG(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .valid_i       (valid_i),
        .ready_o       (ready_o),
        .result_i      (result_i),
        .result2_i     (result2_i),
        .destination_i (destination_i),
        .destination2_i(destination2_i),
        .rd_addr1_i    (rd_addr1_i),
        .rd_data1_o    (rd_data1_o),
        .rd_addr2_i    (rd_addr2_i),
        .rd_data2_o    (rd_data2_o),
        .write_count_o (write_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register array, commit count, and one pending second write.
    logic [31:0] m_gr [32];
    logic [31:0] m_cnt;
    logic        m_pend;
    logic [4:0]  m_pd;
    logic [31:0] m_pdata;

    // What gets committed on the coming edge, derived from the bundle rules.
    logic        w_en;
    logic [4:0]  w_a;
    logic [31:0] w_d;
    logic        w_split;

    always_comb begin
        w_en    = 1'b0;
        w_a     = 5'd0;
        w_d     = 32'd0;
        w_split = 1'b0;
        if (m_pend) begin
            w_en = 1'b1;
            w_a  = m_pd;
            w_d  = m_pdata;
        end else if (valid_i) begin
            if (destination2_i == 5'd0) begin
                w_a  = destination_i;
                w_d  = result_i;
                w_en = (destination_i != 5'd0);
            end else if (destination_i == 5'd0 || destination_i == destination2_i) begin
                w_a  = destination2_i;
                w_d  = result2_i;
                w_en = 1'b1;
            end else begin
                w_a     = destination_i;
                w_d     = result_i;
                w_en    = 1'b1;
                w_split = 1'b1;
            end
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) m_gr[i] <= 32'd0;
            m_cnt   <= 32'd0;
            m_pend  <= 1'b0;
            m_pd    <= 5'd0;
            m_pdata <= 32'd0;
        end else begin
            if (w_en) begin
                m_gr[w_a] <= w_d;
                m_cnt     <= m_cnt + 32'd1;
            end
            if (m_pend) begin
                m_pend <= 1'b0;
            end else if (w_split) begin
                m_pend  <= 1'b1;
                m_pd    <= destination2_i;
                m_pdata <= result2_i;
            end
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
`ifdef WB_BYPASS_EN
        if (w_en && w_a == a) return w_d;
`endif
        return m_gr[a];
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Compare process: outputs checked against the model every cycle.
    always @(negedge clk) begin
        chk("ready", 32'(ready_o), 32'(!m_pend));
        chk("count", write_count_o, m_cnt);
        chk("rd1", rd_data1_o, exp_rd(rd_addr1_i));
        chk("rd2", rd_data2_o, exp_rd(rd_addr2_i));
    end

    task automatic drive(input logic v, input logic [31:0] r, input logic [31:0] r2,
                         input logic [4:0] d1, input logic [4:0] d2);
        valid_i        = v;
        result_i       = r;
        result2_i      = r2;
        destination_i  = d1;
        destination2_i = d2;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] rnd_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        rd_addr1_i = 5'd0;
        rd_addr2_i = 5'd0;
        drive(1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_count", write_count_o, 32'd0);
        rst_n = 1'b1;

        // Single write to r5
        rd_addr1_i = 5'd5;
        drive(1'b1, 32'h12345678, 32'd0, 5'd5, 5'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("single_r5", rd_data1_o, 32'h12345678);
        chk("single_count", write_count_o, 32'd1);
        chk("single_ready", 32'(ready_o), 32'd1);

        // DIV style dual write r3/r4
        rd_addr1_i = 5'd3;
        rd_addr2_i = 5'd4;
        drive(1'b1, 32'd7, 32'd2, 5'd3, 5'd4);
        step();
        chk("div_busy", 32'(ready_o), 32'd0);
        chk("div_r3", rd_data1_o, 32'd7);
        step();
        valid_i = 1'b0;
        #1;
        chk("div_r4", rd_data2_o, 32'd2);
        chk("div_count", write_count_o, 32'd3);
        chk("div_ready", 32'(ready_o), 32'd1);

        // Colliding destinations: result2 wins, single cycle
        drive(1'b1, 32'd7, 32'd9, 5'd4, 5'd4);
        step();
        valid_i = 1'b0;
        #1;
        chk("coll_ready", 32'(ready_o), 32'd1);
        chk("coll_r4", rd_data2_o, 32'd9);
        chk("coll_r3", rd_data1_o, 32'd7);
        chk("coll_count", write_count_o, 32'd4);

        // r0 write suppressed
        rd_addr1_i = 5'd0;
        drive(1'b1, 32'hFFFFFFFF, 32'd0, 5'd0, 5'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("r0_read", rd_data1_o, 32'd0);
        chk("r0_count", write_count_o, 32'd4);

        // Back-to-back dual bundles with valid held
        rd_addr1_i = 5'd1;
        rd_addr2_i = 5'd2;
        drive(1'b1, 32'd11, 32'd12, 5'd1, 5'd2);
        step();
        chk("bp_busy1", 32'(ready_o), 32'd0);
        step();
        chk("bp_free", 32'(ready_o), 32'd1);
        drive(1'b1, 32'd13, 32'd14, 5'd3, 5'd4);
        step();
        chk("bp_busy2", 32'(ready_o), 32'd0);
        step();
        valid_i = 1'b0;
        #1;
        chk("bp_count", write_count_o, 32'd8);
        chk("bp_r1", rd_data1_o, 32'd11);
        chk("bp_r2", rd_data2_o, 32'd12);
        rd_addr1_i = 5'd3;
        rd_addr2_i = 5'd4;
        #1;
        chk("bp_r3", rd_data1_o, 32'd13);
        chk("bp_r4", rd_data2_o, 32'd14);

        // Same-cycle read of r9 while it is being written
        rd_addr2_i = 5'd9;
        drive(1'b1, 32'hCAFEBABE, 32'd0, 5'd9, 5'd0);
        #1;
`ifdef WB_BYPASS_EN
        chk("byp_same", rd_data2_o, 32'hCAFEBABE);
`else
        chk("byp_same", rd_data2_o, 32'd0);
`endif
        step();
        valid_i = 1'b0;
        #1;
        chk("byp_after", rd_data2_o, 32'hCAFEBABE);
        chk("byp_count", write_count_o, 32'd9);

        // Reset while a second write to r7 is pending
        rd_addr1_i = 5'd6;
        rd_addr2_i = 5'd7;
        drive(1'b1, 32'd5, 32'd6, 5'd6, 5'd7);
        step();
        chk("rst2_busy", 32'(ready_o), 32'd0);
        rst_n = 1'b0;
        valid_i = 1'b0;
        #1;
        chk("rst2_ready", 32'(ready_o), 32'd1);
        chk("rst2_count", write_count_o, 32'd0);
        chk("rst2_r6", rd_data1_o, 32'd0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst2_r7", rd_data2_o, 32'd0);
        chk("rst2_count_after", write_count_o, 32'd0);

        // Randomized bundles; bundle held stable while the model says busy
        for (int n = 0; n < 600; n++) begin
            if (!m_pend) begin
                drive(1'($urandom_range(0, 9) < 7), $urandom, $urandom, rnd_addr(), rnd_addr());
            end
            rd_addr1_i = rnd_addr();
            rd_addr2_i = rnd_addr();
            step();
        end
        while (m_pend) step();
        valid_i = 1'b0;
        step();
        step();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
